// File: rtl/line_reverse_pingpong.sv
// Ping-pong line buffer: fills one bank while the other is read out,
// optionally in reverse order, with a two-stage registered output.
module line_reverse_pingpong #(
    parameter int LINE_W = 640,
    parameter int DATA_W = 12
) (
    input  logic              iCCD_PIXCLK,
    input  logic              iRST_N,
    input  logic [DATA_W-1:0] iCCD_R,
    input  logic [DATA_W-1:0] iCCD_G,
    input  logic [DATA_W-1:0] iCCD_B,
    input  logic              iCCD_DVAL,
    input  logic              iMIRROR_EN,
    input  logic              iFLUSH,
    output logic [DATA_W-1:0] oCCD_R,
    output logic [DATA_W-1:0] oCCD_G,
    output logic [DATA_W-1:0] oCCD_B,
    output logic              oCCD_DVAL,
    output logic              oLINE_DONE
);

    localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int PW = 3 * DATA_W;
    localparam logic [AW-1:0] LAST = AW'(LINE_W - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    logic [PW-1:0] bank0 [0:LINE_W-1];
    logic [PW-1:0] bank1 [0:LINE_W-1];

    logic          wrBank;
    logic [AW-1:0] wrCnt;
    logic          wrEn;
    logic          wrLast;
    logic          swap;
    logic [PW-1:0] wrPix;

    logic [0:0]    state;
    logic          rdBank;
    logic          rdMirror;
    logic [AW-1:0] rdCnt;
    logic [AW-1:0] rdAddr;
    logic          rdEn;
    logic          rdLastIss;

    logic [PW-1:0] ramQ;
    logic          ramVal;
    logic          ramLast;

    // Flush wins over any write, so a flushed pixel never reaches a bank.
    assign wrEn      = iCCD_DVAL && !iFLUSH;
    assign wrLast    = (wrCnt == LAST);
    assign swap      = wrEn && wrLast;
    assign wrPix     = {iCCD_R, iCCD_G, iCCD_B};

    assign rdEn      = (state == READ);
    assign rdLastIss = (rdCnt == LAST);
    assign rdAddr    = rdMirror ? (LAST - rdCnt) : rdCnt;

    always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wrCnt  <= '0;
            wrBank <= 1'b0;
        end else if (iFLUSH) begin
            wrCnt  <= '0;
        end else if (wrEn) begin
            if (wrLast) begin
                wrCnt  <= '0;
                wrBank <= ~wrBank;
            end else begin
                wrCnt  <= wrCnt + AW'(1);
            end
        end
    end

    // Bank storage: no reset, contents are only visible after a full line.
    always_ff @(posedge iCCD_PIXCLK) begin
        if (wrEn) begin
            if (wrBank) bank1[wrCnt] <= wrPix;
            else        bank0[wrCnt] <= wrPix;
        end
        if (rdEn) begin
            ramQ <= rdBank ? bank1[rdAddr] : bank0[rdAddr];
        end
    end

    // A swap on the final-read edge restarts READ directly, keeping output contiguous.
    always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= IDLE;
            rdCnt    <= '0;
            rdBank   <= 1'b0;
            rdMirror <= 1'b0;
        end else if (iFLUSH) begin
            state    <= IDLE;
            rdCnt    <= '0;
        end else if (swap) begin
            state    <= READ;
            rdCnt    <= '0;
            rdBank   <= wrBank;
            rdMirror <= iMIRROR_EN;
        end else if (rdEn) begin
            if (rdLastIss) begin
                state <= IDLE;
                rdCnt <= '0;
            end else begin
                rdCnt <= rdCnt + AW'(1);
            end
        end
    end

    always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ramVal  <= 1'b0;
            ramLast <= 1'b0;
        end else if (iFLUSH) begin
            ramVal  <= 1'b0;
            ramLast <= 1'b0;
        end else begin
            ramVal  <= rdEn;
            ramLast <= rdEn && rdLastIss;
        end
    end

    always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oCCD_DVAL  <= 1'b0;
            oLINE_DONE <= 1'b0;
            oCCD_R     <= '0;
            oCCD_G     <= '0;
            oCCD_B     <= '0;
        end else if (iFLUSH) begin
            oCCD_DVAL  <= 1'b0;
            oLINE_DONE <= 1'b0;
            oCCD_R     <= '0;
            oCCD_G     <= '0;
            oCCD_B     <= '0;
        end else begin
            oCCD_DVAL  <= ramVal;
            oLINE_DONE <= ramVal && ramLast;
            {oCCD_R, oCCD_G, oCCD_B} <= ramVal ? ramQ : '0;
        end
    end

endmodule

// File: doc/line_reverse_pingpong.md
LINE_REVERSE_PINGPONG -- requirements
Module: line_reverse_pingpong

Interface
REQ-001 SHALL have parameter LINE_W, default 640: pixels per line; legal values 4 to 1024.
REQ-002 SHALL have parameter DATA_W, default 12: bits per colour channel.
REQ-003 SHALL have input iCCD_PIXCLK, 1 bit: clock; all logic is rising-edge.
REQ-004 SHALL have input iRST_N, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have inputs iCCD_R, iCCD_G and iCCD_B, each DATA_W bits: input pixel channels.
REQ-006 SHALL have input iCCD_DVAL, 1 bit: input pixel valid; at most one pixel per clock, gaps allowed.
REQ-007 SHALL have input iMIRROR_EN, 1 bit: 1 = emit each line reversed; 0 = emit in arrival order.
REQ-008 SHALL have input iFLUSH, 1 bit: synchronous abort; discards the partial line and any line in readout.
REQ-009 SHALL have outputs oCCD_R, oCCD_G and oCCD_B, each DATA_W bits: output pixel channels, registered.
REQ-010 SHALL have output oCCD_DVAL, 1 bit: output pixel valid, registered.
REQ-011 SHALL have output oLINE_DONE, 1 bit: one-cycle pulse on the cycle carrying the last output pixel of a line.

Function
REQ-012 SHALL contain two line banks (0, 1), each LINE_W x 3*DATA_W, dual-port, with 1-cycle registered read.
REQ-013 Write side SHALL hold wr_bank and wr_cnt (0..LINE_W-1); each cycle with iCCD_DVAL=1 writes {R,G,B} at wr_cnt in wr_bank and increments wr_cnt.
REQ-014 When the pixel at wr_cnt = LINE_W-1 is written, wr_cnt SHALL wrap to 0, wr_bank SHALL toggle, and a swap event SHALL fire on that edge.
REQ-015 Reader FSM SHALL have states IDLE and READ.
REQ-016 On a swap event the FSM SHALL go IDLE->READ, set rd_bank to the just-filled bank, set rd_cnt=0, and latch iMIRROR_EN into rd_mirror.
REQ-017 In READ, each cycle SHALL issue one read at address (rd_mirror ? LINE_W-1-rd_cnt : rd_cnt) and increment rd_cnt.
REQ-018 After issuing rd_cnt = LINE_W-1 the FSM SHALL return to IDLE; exactly LINE_W reads are issued per line.
REQ-019 Read data SHALL appear on oCCD_* with oCCD_DVAL=1 two cycles after issue (RAM stage plus output register).
REQ-020 Output SHALL therefore be contiguous: for a swap at edge k, oCCD_DVAL is high after edges k+2 through k+LINE_W+1.
REQ-021 oCCD_R, oCCD_G and oCCD_B SHALL be 0 whenever oCCD_DVAL=0.
REQ-022 oLINE_DONE SHALL be 1 exactly with the LINE_W-th valid output pixel of each line.
REQ-023 Because input rate is at most 1 pixel/clock, the next swap can occur no earlier than the edge issuing the final read; a swap on that same edge SHALL be accepted and SHALL start the next READ on the following cycle with no gap and no lost line.
REQ-024 iMIRROR_EN changes SHALL affect only lines whose swap occurs after the change; a line already in readout keeps its order.
REQ-025 iFLUSH=1 SHALL clear wr_cnt, force the FSM to IDLE, and cancel pending valid stages, so oCCD_DVAL=0 from the next edge.
REQ-026 iFLUSH SHALL leave wr_bank unchanged, and it takes priority over a simultaneous iCCD_DVAL write or swap.
REQ-027 Bank contents SHALL be left uninitialised; no data is emitted before the first complete line.

Reset
REQ-028 On iRST_N=0, asynchronously: wr_cnt=0, wr_bank=0, FSM=IDLE, rd_cnt=0, rd_mirror=0, pipeline valids=0, oCCD_DVAL=0, oLINE_DONE=0, oCCD_R/G/B=0.
REQ-029 Reset asserted mid-line or mid-readout SHALL discard all partial work; the first output after release follows the first complete line written after release.

Verification (LINE_W=8, DATA_W=12)
REQ-030 Mirror: iMIRROR_EN=1; 8 contiguous pixels R=G=B=0..7 -> oCCD_DVAL high 8 cycles starting 2 cycles after the last input; outputs 7,6,...,0; oLINE_DONE with 0.
REQ-031 Passthrough plus gaps: iMIRROR_EN=0; pixels 0..7 with DVAL toggling every other cycle -> output 0..7 contiguous after the 8th input.
REQ-032 Back-to-back: 3 lines of 24 contiguous pixels (values 0..23), iMIRROR_EN=1 -> 24 contiguous outputs 7..0, 15..8, 23..16; three oLINE_DONE pulses; no gaps.
REQ-033 Mode change mid-readout: toggle iMIRROR_EN 0->1 during readout of line A -> line A stays in order, line B (swap after toggle) is reversed.
REQ-034 Flush: 5 pixels, iFLUSH pulse, then 8 pixels 10..17, iMIRROR_EN=1 -> only 17..10 emitted; the first 5 pixels never appear.
REQ-035 Async reset during readout (after 3 outputs) -> all outputs 0 immediately; no further output until a new full line arrives.
